dpcm_line_sequencer: RTL and testbench

Frame/line controller that sequences the DPCM predictor over a raster frame. It accepts the sensor pixel stream with a valid/ready handshake and forwards pixels to the predictor. Before each line it injects one seed pixel of 0, so the first residual of every line equals the raw pixel and lines decode independently. It discards the seed results, tags the surviving residuals with frame/line markers, and buffers them in a small output FIFO that gives the encoder backpressure the predictor itself lacks.

---
 rtl/dpcm_line_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_dpcm_line_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpcm_line_sequencer.sv
// Frame/line sequencer for the DPCM predictor: injects a zero seed before each line,
// tags surviving residuals with frame/line markers and buffers them in a small FIFO.
module dpcm_line_sequencer #(
    parameter int unsigned COLS_W     = 11,
    parameter int unsigned ROWS_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COLS_W-1:0] cfg_cols,
    input  logic [ROWS_W-1:0] cfg_rows,
    output logic              busy,
    output logic              frame_done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_pixel,
    output logic              pred_valid_in,
    output logic [15:0]       pred_pixel_in,
    input  logic              pred_valid_out,
    input  logic [16:0]       pred_residual,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [16:0]       m_residual,
    output logic              m_sof,
    output logic              m_sol,
    output logic              m_eol,
    output logic              m_eof
);

    localparam int unsigned PIX_W = 16;
    localparam int unsigned RES_W = 17;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, SEED, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic drop;
        logic sof;
        logic sol;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        logic [RES_W-1:0] residual;
        logic             sof;
        logic             sol;
        logic             eol;
        logic             eof;
    } entry_t;

    state_t            state_q, state_d;
    logic [COLS_W-1:0] cols_q, cols_d, col_q, col_d;
    logic [ROWS_W-1:0] rows_q, rows_d, row_q, row_d;
    logic [PIX_W-1:0]  last_pix_q;
    logic              inflight_q;
    logic              fire;
    logic              done_d;
    logic              eol_c, last_row_c;
    tag_t              tag_q, tag_d;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  wr_idx;
    logic              push, pop;
    entry_t            wr_entry;

    assign eol_c      = (col_q == cols_q - COLS_W'(1));
    assign last_row_c = (row_q == rows_q - ROWS_W'(1));

    assign m_valid    = (fifo_count != '0);
    assign pop        = m_valid && m_ready;
    assign push       = pred_valid_out && !tag_q.drop;
    assign m_residual = fifo_mem[0].residual;
    assign m_sof      = fifo_mem[0].sof;
    assign m_sol      = fifo_mem[0].sol;
    assign m_eol      = fifo_mem[0].eol;
    assign m_eof      = fifo_mem[0].eof;

    // Next-state, counters, predictor drive and tag generation
    always_comb begin
        state_d       = state_q;
        cols_d        = cols_q;
        rows_d        = rows_q;
        col_d         = col_q;
        row_d         = row_q;
        tag_d         = tag_q;
        s_ready       = 1'b0;
        fire          = 1'b0;
        pred_valid_in = 1'b0;
        pred_pixel_in = last_pix_q;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (cfg_cols != '0) && (cfg_rows != '0)) begin
                    cols_d  = cfg_cols;
                    rows_d  = cfg_rows;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = SEED;
                end
            end
            SEED: begin
                pred_valid_in = 1'b1;
                pred_pixel_in = '0;
                tag_d         = '{drop: 1'b1, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
                state_d       = STREAM;
            end
            STREAM: begin
                // Reserve FIFO room for every pixel still inside the predictor
                s_ready = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
                fire    = s_valid && s_ready;
                if (fire) begin
                    pred_valid_in = 1'b1;
                    pred_pixel_in = s_pixel;
                    tag_d = '{drop: 1'b0,
                              sof:  (row_q == '0) && (col_q == '0),
                              sol:  (col_q == '0),
                              eol:  eol_c,
                              eof:  eol_c && last_row_c};
                    if (eol_c) begin
                        col_d = '0;
                        if (last_row_c) begin
                            state_d = DRAIN;
                        end else begin
                            row_d   = row_q + ROWS_W'(1);
                            state_d = SEED;
                        end
                    end else begin
                        col_d = col_q + COLS_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (fifo_count == CNT_W'(1)) && pop && m_eof) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            last_pix_q <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            col_q      <= col_d;
            row_q      <= row_d;
            if (pred_valid_in) begin
                last_pix_q <= pred_pixel_in;
            end
            inflight_q <= fire;
            tag_q      <= tag_d;
            frame_done <= done_d;
            busy       <= (state_d != IDLE);
        end
    end

    assign wr_idx   = pop ? (fifo_count - CNT_W'(1)) : fifo_count;
    assign wr_entry = '{residual: pred_residual, sof: tag_q.sof, sol: tag_q.sol,
                        eol: tag_q.eol, eof: tag_q.eof};

    // Shift-register FIFO: entry 0 is always the registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                    fifo_mem[IDX_W'(i)] <= fifo_mem[IDX_W'(i + 1)];
                end
            end
            if (push) begin
                fifo_mem[IDX_W'(wr_idx)] <= wr_entry;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_dpcm_line_sequencer.sv
// Directed bench for dpcm_line_sequencer with a behavioural 1-cycle DPCM predictor.
module tb_dpcm_line_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] cfg_cols;
    logic [9:0]  cfg_rows;
    logic        busy, frame_done;
    logic        s_valid, s_ready;
    logic [15:0] s_pixel;
    logic        pred_valid_in;
    logic [15:0] pred_pixel_in;
    logic        pred_valid_out;
    logic [16:0] pred_residual;
    logic        m_valid, m_ready;
    logic [16:0] m_residual;
    logic        m_sof, m_sol, m_eol, m_eof;

    dpcm_line_sequencer #(.COLS_W(11), .ROWS_W(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .busy(busy), .frame_done(frame_done),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .pred_valid_in(pred_valid_in), .pred_pixel_in(pred_pixel_in),
        .pred_valid_out(pred_valid_out), .pred_residual(pred_residual),
        .m_valid(m_valid), .m_ready(m_ready), .m_residual(m_residual),
        .m_sof(m_sof), .m_sol(m_sol), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    // Predictor model: residual = pixel - previous pixel, one cycle latency
    logic [15:0] prev_pix;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_out <= 1'b0;
            pred_residual  <= '0;
            prev_pix       <= '0;
        end else begin
            pred_valid_out <= pred_valid_in;
            if (pred_valid_in) begin
                pred_residual <= {1'b0, pred_pixel_in} - {1'b0, prev_pix};
                prev_pix      <= pred_pixel_in;
            end
        end
    end

    typedef struct packed {
        logic [10:0]      cols;
        logic [9:0]       rows;
        logic             mode;
        logic [3:0]       n;
        logic [7:0][15:0] px;
        logic [7:0][16:0] res;
        logic [7:0][3:0]  tg;
    } vec_t;

    vec_t        vecs [3];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          seed_cnt = 0;
    int          stall_cnt = 0;
    int          pvi_cnt = 0;
    int          cyc = 0;
    logic        mode = 1'b0;
    logic [20:0] got_q [$];
    logic        hold_pend = 1'b0;
    logic [20:0] hold_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Backpressure driver: always ready, or the 1,0,0,1 pattern
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            m_ready = mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        end
    end

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_q.push_back({m_residual, m_sof, m_sol, m_eol, m_eof});
            if (frame_done) done_cnt++;
            if (pred_valid_in && !(s_valid && s_ready)) seed_cnt++;
            if (busy && s_valid && !s_ready && !pred_valid_in) stall_cnt++;
            if (pred_valid_in) pvi_cnt++;
            if (hold_pend && m_valid)
                chk("hold_stable", 32'({m_residual, m_sof, m_sol, m_eol, m_eof}), 32'(hold_val));
            hold_pend = m_valid && !m_ready;
            hold_val  = {m_residual, m_sof, m_sol, m_eol, m_eof};
            if (dut.fifo_count > 3'd4) chk("fifo_overflow", 32'(dut.fifo_count), 32'd4);
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic chk_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_pred_valid_in", 32'(pred_valid_in), 0);
        chk("rst_pred_pixel_in", 32'(pred_pixel_in), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_residual", 32'(m_residual), 0);
        chk("rst_m_tags", 32'({m_sof, m_sol, m_eol, m_eof}), 0);
    endtask

    task automatic run_frame(input vec_t v, input bit extra, input bit abort);
        int k, budget, d0, s0;
        bit acc, did, first;
        got_q.delete();
        d0 = done_cnt; s0 = seed_cnt; stall_cnt = 0; mode = v.mode;
        @(posedge clk); #1;
        cfg_cols = v.cols; cfg_rows = v.rows; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_pixel = v.px[0];
        @(negedge clk);
        chk("seed_valid", 32'(pred_valid_in), 1);
        chk("seed_pixel", 32'(pred_pixel_in), 0);
        chk("seed_s_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        k = 0; budget = 0; did = 0; first = 1;
        while (k < int'(v.n) && budget < 400) begin
            @(negedge clk);
            if (first) begin
                chk("first_s_ready", 32'(s_ready), 1);
                first = 0;
            end
            acc = s_ready;
            @(posedge clk); #1;
            budget++;
            start = 1'b0;
            if (acc) begin
                k++;
                if (k < int'(v.n)) s_pixel = v.px[k];
                else s_valid = 1'b0;
            end
            if (extra && k == 2 && !did) begin
                start = 1'b1; cfg_cols = 11'd1; cfg_rows = 10'd1; did = 1;
            end
            if (abort && k == 6) return;
        end
        chk("accept_budget", 32'(budget < 400), 1);
        budget = 0;
        while (done_cnt == d0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        chk("frame_done_seen", 32'(done_cnt != d0), 1);
        repeat (6) @(negedge clk);
        chk("frame_done_count", 32'(done_cnt - d0), 1);
        chk("seed_count", 32'(seed_cnt - s0), 32'(v.rows));
        chk("out_count", 32'(got_q.size()), 32'(v.n));
        for (int i = 0; i < int'(v.n) && i < got_q.size(); i++) begin
            chk($sformatf("residual[%0d]", i), 32'(got_q[i][20:4]), 32'(v.res[i]));
            chk($sformatf("tags[%0d]", i), 32'(got_q[i][3:0]), 32'(v.tg[i]));
        end
        if (v.mode) chk("stall_seen", 32'(stall_cnt > 0), 1);
        else chk("no_stall", 32'(stall_cnt), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '0;
        vecs[0].cols = 11'd4; vecs[0].rows = 10'd2; vecs[0].mode = 1'b0; vecs[0].n = 4'd8;
        vecs[0].px[0] = 16'd100; vecs[0].px[1] = 16'd105; vecs[0].px[2] = 16'd103; vecs[0].px[3] = 16'd103;
        vecs[0].px[4] = 16'd200; vecs[0].px[5] = 16'd190; vecs[0].px[6] = 16'd190; vecs[0].px[7] = 16'd65535;
        vecs[0].res[0] = 17'd100;     vecs[0].res[1] = 17'd5;  vecs[0].res[2] = 17'h1FFFE; vecs[0].res[3] = 17'd0;
        vecs[0].res[4] = 17'd200;     vecs[0].res[5] = 17'h1FFF6; vecs[0].res[6] = 17'd0;  vecs[0].res[7] = 17'd65345;
        vecs[0].tg[0] = 4'b1100; vecs[0].tg[3] = 4'b0010; vecs[0].tg[4] = 4'b0100; vecs[0].tg[7] = 4'b0011;
        vecs[1] = vecs[0];
        vecs[1].mode = 1'b1;
        vecs[2] = '0;
        vecs[2].cols = 11'd1; vecs[2].rows = 10'd1; vecs[2].n = 4'd1;
        vecs[2].px[0] = 16'd7; vecs[2].res[0] = 17'd7; vecs[2].tg[0] = 4'b1111;

        rst = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0; s_valid = 1'b0; s_pixel = '0;
        repeat (2) @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 3; t++) run_frame(vecs[t], 1'b0, 1'b0);

        // Zero-column start must be ignored
        pvi_cnt = 0;
        @(posedge clk); #1;
        cfg_cols = 11'd0; cfg_rows = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("zero_cfg_busy", 32'(busy), 0);
        chk("zero_cfg_pred", 32'(pvi_cnt), 0);

        // Second start while busy is ignored
        run_frame(vecs[0], 1'b1, 1'b0);

        // Reset in the middle of row 1, then a fresh frame
        run_frame(vecs[0], 1'b0, 1'b1);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(vecs[2], 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
